control_sequencer: RTL and testbench

- Hardwired control unit directly upstream of the datapath.
- Fetches each instruction and decodes IR_Data[31:27].
- Drives every datapath enable, select, read and ALU-opcode signal, one T-state per clock.
- Replaces the hand-sequenced control stimulus used when exercising the datapath alone.
- Covers fetch, three-operand ALU ops, mul/div (HI/LO write-back), nop and halt.

---
 rtl/control_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Hardwired control unit placed in front of the datapath. It fetches
//            each instruction, decodes IR[31:27], and steps through one T-state
//            per clock. It drives every datapath select, enable, read and ALU
//            opcode line.
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer #(
   parameter int              OPW     = 5,
   parameter logic [OPW-1:0]  OP_MUL  = 5'b01111,
   parameter logic [OPW-1:0]  OP_DIV  = 5'b10000,
   parameter logic [OPW-1:0]  OP_NOP  = 5'b11010,
   parameter logic [OPW-1:0]  OP_HALT = 5'b11011
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [31:0]    IR_Data,
   input  logic           mem_ready,
   input  logic           stop,
   output logic           run,
   output logic           PC_select,
   output logic           Z_LO_select,
   output logic           Z_HI_select,
   output logic           MDR_select,
   output logic           Rout,
   output logic           PC_enable,
   output logic           PC_increment_enable,
   output logic           IR_enable,
   output logic           Y_enable,
   output logic           Z_enable,
   output logic           MAR_enable,
   output logic           MDR_enable,
   output logic           HI_enable,
   output logic           LO_enable,
   output logic           Rin,
   output logic           Gra,
   output logic           Grb,
   output logic           Grc,
   output logic           read,
   output logic [OPW-1:0] alu_instruction
);

   // Opcodes from ALU_FIRST through ALU_LAST are three-operand register ALU ops
   localparam logic [OPW-1:0] C_OP_ALU_FIRST = 5'b00011;
   localparam logic [OPW-1:0] C_OP_ALU_LAST  = 5'b01110;

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH0 = 4'd1,
      S_FETCH1 = 4'd2,
      S_FETCH2 = 4'd3,
      S_DECODE = 4'd4,
      S_T3     = 4'd5,
      S_T4     = 4'd6,
      S_T5     = 4'd7,
      S_T6     = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   state_t         r_state;
   state_t         w_next_state;
   logic [OPW-1:0] r_op;
   logic [OPW-1:0] w_ir_op;
   logic           w_ir_is_alu;
   logic           w_ir_is_muldiv;
   logic           w_op_is_muldiv;
   logic           w_unused_ir;

   // Only the opcode field is decoded here. The register fields go straight to
   // the datapath's Gra/Grb/Grc decoder.
   assign w_ir_op        = IR_Data[31 -: OPW];
   assign w_unused_ir    = ^IR_Data[31-OPW:0];
   assign w_ir_is_alu    = (w_ir_op >= C_OP_ALU_FIRST) && (w_ir_op <= C_OP_ALU_LAST);
   assign w_ir_is_muldiv = (w_ir_op == OP_MUL) || (w_ir_op == OP_DIV);
   assign w_op_is_muldiv = (r_op == OP_MUL) || (r_op == OP_DIV);

   // State register; reset drops straight to RESET, which forces every output low
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_RESET;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Latch the opcode when leaving DECODE so the execute states are independent of IR
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op <= '0;
      end else if (r_state == S_DECODE) begin
         r_op <= w_ir_op;
      end
   end

   // Next-state and per-state control outputs; all outputs default low
   always_comb begin
      w_next_state        = r_state;
      run                 = 1'b0;
      PC_select           = 1'b0;
      Z_LO_select         = 1'b0;
      Z_HI_select         = 1'b0;
      MDR_select          = 1'b0;
      Rout                = 1'b0;
      PC_enable           = 1'b0;
      PC_increment_enable = 1'b0;
      IR_enable           = 1'b0;
      Y_enable            = 1'b0;
      Z_enable            = 1'b0;
      MAR_enable          = 1'b0;
      MDR_enable          = 1'b0;
      HI_enable           = 1'b0;
      LO_enable           = 1'b0;
      Rin                 = 1'b0;
      Gra                 = 1'b0;
      Grb                 = 1'b0;
      Grc                 = 1'b0;
      read                = 1'b0;
      alu_instruction     = '0;
      case (r_state)
         S_RESET: begin
            w_next_state = S_FETCH0;
         end
         S_FETCH0: begin
            run = 1'b1;
            // A stop request suppresses the fetch so MAR and PC stay untouched
            if (stop) begin
               w_next_state = S_HALT;
            end else begin
               PC_select           = 1'b1;
               MAR_enable          = 1'b1;
               PC_increment_enable = 1'b1;
               Z_enable            = 1'b1;
               w_next_state        = S_FETCH1;
            end
         end
         S_FETCH1: begin
            // Waiting here reloads PC with the same Z_LO value, which is harmless
            run         = 1'b1;
            Z_LO_select = 1'b1;
            PC_enable   = 1'b1;
            read        = 1'b1;
            MDR_enable  = 1'b1;
            if (mem_ready) begin
               w_next_state = S_FETCH2;
            end
         end
         S_FETCH2: begin
            run          = 1'b1;
            MDR_select   = 1'b1;
            IR_enable    = 1'b1;
            w_next_state = S_DECODE;
         end
         S_DECODE: begin
            run = 1'b1;
            if (w_ir_op == OP_HALT) begin
               w_next_state = S_HALT;
            end else if (w_ir_is_alu || w_ir_is_muldiv) begin
               w_next_state = S_T3;
            end else begin
               w_next_state = S_FETCH0;
            end
         end
         S_T3: begin
            run          = 1'b1;
            Rout         = 1'b1;
            Y_enable     = 1'b1;
            Gra          = w_op_is_muldiv;
            Grb          = !w_op_is_muldiv;
            w_next_state = S_T4;
         end
         S_T4: begin
            run             = 1'b1;
            Rout            = 1'b1;
            Z_enable        = 1'b1;
            alu_instruction = r_op;
            Grb             = w_op_is_muldiv;
            Grc             = !w_op_is_muldiv;
            w_next_state    = S_T5;
         end
         S_T5: begin
            run         = 1'b1;
            Z_LO_select = 1'b1;
            if (w_op_is_muldiv) begin
               LO_enable    = 1'b1;
               w_next_state = S_T6;
            end else begin
               Gra          = 1'b1;
               Rin          = 1'b1;
               w_next_state = S_FETCH0;
            end
         end
         S_T6: begin
            run          = 1'b1;
            Z_HI_select  = 1'b1;
            HI_enable    = 1'b1;
            w_next_state = S_FETCH0;
         end
         S_HALT: begin
            w_next_state = S_HALT;
         end
         default: begin
            w_next_state = S_RESET;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Scoreboard bench for control_sequencer. The stimulus pushes the
//            expected control word for each cycle, and a monitor pops and
//            compares it on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] IR_Data = 32'h20228000;
   logic        mem_ready = 1'b1;
   logic        stop = 1'b0;
   logic        run, PC_select, Z_LO_select, Z_HI_select, MDR_select, Rout;
   logic        PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
   logic        MAR_enable, MDR_enable, HI_enable, LO_enable, Rin, Gra, Grb, Grc, read;
   logic [4:0]  alu_instruction;

   control_sequencer dut (
      .clk(clk), .reset(reset), .IR_Data(IR_Data), .mem_ready(mem_ready), .stop(stop),
      .run(run), .PC_select(PC_select), .Z_LO_select(Z_LO_select),
      .Z_HI_select(Z_HI_select), .MDR_select(MDR_select), .Rout(Rout),
      .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
      .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
      .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .HI_enable(HI_enable),
      .LO_enable(LO_enable), .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .read(read), .alu_instruction(alu_instruction)
   );

   always #5 clk = ~clk;

   // Packed control word, run at bit 24 down to alu_instruction at [4:0]
   logic [24:0] obs;
   assign obs = {run, PC_select, Z_LO_select, Z_HI_select, MDR_select, Rout,
                 PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
                 MAR_enable, MDR_enable, HI_enable, LO_enable, Rin, Gra, Grb,
                 Grc, read, alu_instruction};

   localparam logic [24:0] B_RUN = 25'h1 << 24, B_PCSEL = 25'h1 << 23;
   localparam logic [24:0] B_ZLO = 25'h1 << 22, B_ZHI = 25'h1 << 21;
   localparam logic [24:0] B_MDRSEL = 25'h1 << 20, B_ROUT = 25'h1 << 19;
   localparam logic [24:0] B_PCEN = 25'h1 << 18, B_PCINC = 25'h1 << 17;
   localparam logic [24:0] B_IREN = 25'h1 << 16, B_YEN = 25'h1 << 15;
   localparam logic [24:0] B_ZEN = 25'h1 << 14, B_MAREN = 25'h1 << 13;
   localparam logic [24:0] B_MDREN = 25'h1 << 12, B_HIEN = 25'h1 << 11;
   localparam logic [24:0] B_LOEN = 25'h1 << 10, B_RIN = 25'h1 << 9;
   localparam logic [24:0] B_GRA = 25'h1 << 8, B_GRB = 25'h1 << 7;
   localparam logic [24:0] B_GRC = 25'h1 << 6, B_READ = 25'h1 << 5;

   localparam logic [24:0] E_ZERO  = 25'h0;
   localparam logic [24:0] E_F0    = B_RUN | B_PCSEL | B_MAREN | B_PCINC | B_ZEN;
   localparam logic [24:0] E_F0STP = B_RUN;
   localparam logic [24:0] E_F1    = B_RUN | B_ZLO | B_PCEN | B_READ | B_MDREN;
   localparam logic [24:0] E_F2    = B_RUN | B_MDRSEL | B_IREN;
   localparam logic [24:0] E_DEC   = B_RUN;
   localparam logic [24:0] E_RT3   = B_RUN | B_GRB | B_ROUT | B_YEN;
   localparam logic [24:0] E_RT4   = B_RUN | B_GRC | B_ROUT | B_ZEN;
   localparam logic [24:0] E_RT5   = B_RUN | B_ZLO | B_GRA | B_RIN;
   localparam logic [24:0] E_MT3   = B_RUN | B_GRA | B_ROUT | B_YEN;
   localparam logic [24:0] E_MT4   = B_RUN | B_GRB | B_ROUT | B_ZEN;
   localparam logic [24:0] E_MT5   = B_RUN | B_ZLO | B_LOEN;
   localparam logic [24:0] E_MT6   = B_RUN | B_ZHI | B_HIEN;

   typedef struct {
      logic [24:0] v;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   event sample_now;

   // One cycle: apply inputs just after the rising edge and queue this cycle's expected word
   task automatic step(input logic [24:0] v, input string nm, input logic mr, input logic st);
      exp_t e;
      @(posedge clk);
      #1;
      mem_ready = mr;
      stop      = st;
      e.v  = v;
      e.nm = nm;
      sb.push_back(e);
   endtask

   // Monitor: compare on each falling edge, or on demand for asynchronous effects
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or sample_now);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v) begin
               n_fail++;
               $display("FAIL %s: outputs=%h expected=%h at %0t", e.nm, obs, e.v, $time);
            end
            n_checks++;
            if ($countones({PC_select, Z_LO_select, Z_HI_select, MDR_select, Rout}) > 1) begin
               n_fail++;
               $display("FAIL %s_bus_exclusive: selects=%b expected at most one high", e.nm,
                        {PC_select, Z_LO_select, Z_HI_select, MDR_select, Rout});
            end
         end
      end
   end

   initial begin
      // Reset state, then release
      step(E_ZERO, "reset0", 1'b1, 1'b0);
      step(E_ZERO, "reset1", 1'b1, 1'b0);
      reset = 1'b0;

      // sub R0,R4,R5: 7 clocks FETCH0..T5
      step(E_F0, "sub_f0", 1'b1, 1'b0);
      step(E_F1, "sub_f1", 1'b1, 1'b0);
      step(E_F2, "sub_f2", 1'b1, 1'b0);
      step(E_DEC, "sub_dec", 1'b1, 1'b0);
      step(E_RT3, "sub_t3", 1'b1, 1'b0);
      step(E_RT4 | 25'd4, "sub_t4", 1'b1, 1'b0);
      step(E_RT5, "sub_t5", 1'b1, 1'b0);
      IR_Data = 32'h78000000;

      // mul, with mem_ready low for three FETCH1 cycles
      step(E_F0, "mul_f0", 1'b1, 1'b0);
      step(E_F1, "mul_f1_w0", 1'b0, 1'b0);
      step(E_F1, "mul_f1_w1", 1'b0, 1'b0);
      step(E_F1, "mul_f1_w2", 1'b0, 1'b0);
      step(E_F1, "mul_f1_rdy", 1'b1, 1'b0);
      step(E_F2, "mul_f2", 1'b1, 1'b0);
      step(E_DEC, "mul_dec", 1'b1, 1'b0);
      step(E_MT3, "mul_t3", 1'b1, 1'b0);
      step(E_MT4 | 25'd15, "mul_t4", 1'b1, 1'b0);
      step(E_MT5, "mul_t5", 1'b1, 1'b0);
      step(E_MT6, "mul_t6", 1'b1, 1'b0);
      IR_Data = 32'hF8000000;

      // Undefined opcode 5'b11111 behaves as nop
      step(E_F0, "undef_f0", 1'b1, 1'b0);
      step(E_F1, "undef_f1", 1'b1, 1'b0);
      step(E_F2, "undef_f2", 1'b1, 1'b0);
      step(E_DEC, "undef_dec", 1'b1, 1'b0);

      // stop in FETCH0 suppresses the fetch and halts
      step(E_F0STP, "stop_f0", 1'b1, 1'b1);
      step(E_ZERO, "stop_halt0", 1'b1, 1'b0);
      step(E_ZERO, "stop_halt1", 1'b1, 1'b0);
      step(E_ZERO, "stop_halt2", 1'b1, 1'b0);
      reset = 1'b1;
      step(E_ZERO, "stop_reset", 1'b1, 1'b0);
      reset = 1'b0;
      IR_Data = 32'hD8000000;

      // halt opcode: sticky HALT with all outputs low
      step(E_F0, "halt_f0", 1'b1, 1'b0);
      step(E_F1, "halt_f1", 1'b1, 1'b0);
      step(E_F2, "halt_f2", 1'b1, 1'b0);
      step(E_DEC, "halt_dec", 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(E_ZERO, $sformatf("halt_hold%0d", i), 1'b1, 1'b0);
      end
      reset = 1'b1;
      step(E_ZERO, "halt_reset", 1'b1, 1'b0);
      reset = 1'b0;
      IR_Data = 32'h20228000;

      // Reset asserted in the middle of T4 clears the outputs without a clock edge
      step(E_F0, "abort_f0", 1'b1, 1'b0);
      step(E_F1, "abort_f1", 1'b1, 1'b0);
      step(E_F2, "abort_f2", 1'b1, 1'b0);
      step(E_DEC, "abort_dec", 1'b1, 1'b0);
      step(E_RT3, "abort_t3", 1'b1, 1'b0);
      step(E_RT4 | 25'd4, "abort_t4", 1'b1, 1'b0);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      begin
         exp_t e;
         e.v  = E_ZERO;
         e.nm = "abort_async";
         sb.push_back(e);
      end
      -> sample_now;
      step(E_ZERO, "abort_hold", 1'b1, 1'b0);
      reset = 1'b0;
      step(E_F0, "abort_restart_f0", 1'b1, 1'b0);
      step(E_F1, "abort_restart_f1", 1'b1, 1'b0);

      // Drain the scoreboard
      @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: pending=%0d expected=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
